// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle for mem_arbiter.
// master: the arbiter; slave: the caches and RAM model surrounding it.
interface mem_arbiter_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned STAT_W = 2;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [STAT_W-1:0] ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache onto a single-ported RAM; dcache has priority, grants held until ACCESS.
// Define ARB_FAIR_EN to force an icache grant after STARVE_LIMIT contested dcache completions.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);
  localparam int unsigned STREAK_W   = 4;
  localparam int unsigned WORD_W     = 32;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  state_t state;
  logic   d_req;
  logic   ram_done;
  logic   go_igrant;
  logic   go_dgrant;

`ifdef ARB_FAIR_EN
  logic [STREAK_W-1:0] dstreak;
  logic                d_done;
`endif

  // Arbitration decision, only meaningful while IDLE
  always_comb begin
    d_req    = bus.dREN | bus.dWEN;
    ram_done = (bus.ramstate == RAM_ACCESS);
`ifdef ARB_FAIR_EN
    d_done    = (state == DGRANT) && d_req && ram_done;
    go_igrant = (state == IDLE) && bus.iREN &&
                ((dstreak == STREAK_W'(STARVE_LIMIT)) || !d_req);
`else
    go_igrant = (state == IDLE) && bus.iREN && !d_req;
`endif
    go_dgrant = (state == IDLE) && d_req && !go_igrant;
  end

  // Grant register; a completion or a withdrawn request always returns through IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
`ifdef ARB_FAIR_EN
      dstreak <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go_igrant)      state <= IGRANT;
          else if (go_dgrant) state <= DGRANT;
        end
        DGRANT:  if (!d_req || ram_done) state <= IDLE;
        IGRANT:  if (!bus.iREN || ram_done) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef ARB_FAIR_EN
      if (go_igrant)   dstreak <= '0;
      else if (d_done) dstreak <= bus.iREN ? dstreak + STREAK_W'(1) : '0;
`endif
    end
  end

  // RAM drive and cache responses follow the current grant and live request within the cycle
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      DGRANT: begin
        if (d_req) begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          if (ram_done) begin
            bus.dwait = 1'b0;
            bus.dload = WORD_W'(bus.ramload);
          end
        end
      end
      IGRANT: begin
        if (bus.iREN) begin
          bus.ramaddr = bus.iaddr;
          bus.ramREN  = 1'b1;
          if (ram_done) begin
            bus.iwait = 1'b0;
            bus.iload = WORD_W'(bus.ramload);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against
// a transaction-level ownership model of the arbitration rules.
module tb_mem_arbiter;
  localparam int unsigned LIMIT    = 4;
  localparam logic [1:0]  R_FREE   = 2'd0;
  localparam logic [1:0]  R_BUSY   = 2'd1;
  localparam logic [1:0]  R_ACCESS = 2'd2;
  localparam logic [1:0]  R_ERROR  = 2'd3;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: who currently owns the RAM, plus the starvation streak
  typedef enum int {NONE, DCACHE, ICACHE} owner_t;
  owner_t owner  = NONE;
  int     streak = 0;

  task automatic check_outputs(input string tag);
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    logic        dreq, acc;
    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_iload = '0;   e_dload = '0;   e_addr = '0;  e_store = '0;
    dreq = bus.dREN | bus.dWEN;
    acc  = (bus.ramstate == R_ACCESS);
    if (nrst && owner == DCACHE && dreq) begin
      e_addr  = bus.daddr;
      e_store = bus.dstore;
      if (bus.dWEN) e_wen = 1'b1;
      else          e_ren = 1'b1;
      if (acc) begin e_dwait = 1'b0; e_dload = bus.ramload; end
    end
    if (nrst && owner == ICACHE && bus.iREN) begin
      e_addr = bus.iaddr;
      e_ren  = 1'b1;
      if (acc) begin e_iwait = 1'b0; e_iload = bus.ramload; end
    end
    check({tag, ":waits"},    32'({bus.iwait, bus.dwait}),   32'({e_iwait, e_dwait}));
    check({tag, ":iload"},    bus.iload,                     e_iload);
    check({tag, ":dload"},    bus.dload,                     e_dload);
    check({tag, ":enables"},  32'({bus.ramREN, bus.ramWEN}), 32'({e_ren, e_wen}));
    check({tag, ":ramaddr"},  bus.ramaddr,                   e_addr);
    check({tag, ":ramstore"}, bus.ramstore,                  e_store);
  endtask

  // Model state update for the coming clock edge
  task automatic advance();
    logic dreq, acc;
    dreq = bus.dREN | bus.dWEN;
    acc  = (bus.ramstate == R_ACCESS);
    if (!nrst) begin
      owner  = NONE;
      streak = 0;
    end else begin
      case (owner)
        NONE: begin
          if (FAIR && streak == int'(LIMIT) && bus.iREN) begin owner = ICACHE; streak = 0; end
          else if (dreq)                                 owner = DCACHE;
          else if (bus.iREN)                             begin owner = ICACHE; streak = 0; end
        end
        DCACHE: begin
          if (!dreq) owner = NONE;
          else if (acc) begin
            owner  = NONE;
            streak = bus.iREN ? (streak + 1) % 16 : 0;
          end
        end
        default: if (!bus.iREN || acc) owner = NONE;
      endcase
    end
  endtask

  task automatic set_in(input logic iren, input logic [31:0] ia, input logic dren,
                        input logic dwen, input logic [31:0] da, input logic [31:0] ds,
                        input logic [1:0] rs, input logic [31:0] rl);
    bus.iREN = iren;  bus.iaddr = ia;
    bus.dREN = dren;  bus.dWEN = dwen; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = rs; bus.ramload = rl;
  endtask

  task automatic tick_begin(input string tag);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic tick_end();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    tick_begin("idle");
    tick_end();
  endtask

  logic [1:0] t2_rs [8] = '{R_FREE, R_BUSY, R_BUSY, R_ACCESS, R_FREE, R_BUSY, R_BUSY, R_ACCESS};
  logic [1:0] t3_rs [4] = '{R_FREE, R_BUSY, R_ERROR, R_ACCESS};
  int  dn;
  int  in_i;
  bit  got_i;
  int  r;

  initial begin
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    nrst = 1'b0;
    tick_begin("reset");
    tick_end();
    nrst = 1'b1;
    idle_cycle();

    // Lone icache read with immediate ACCESS
    set_in(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, R_FREE, 32'h0);
    tick_begin("t1c0"); tick_end();
    set_in(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, R_ACCESS, 32'hDEADBEEF);
    tick_begin("t1c1");
    check("t1_iwait_c1", 32'(bus.iwait), 32'd0);
    check("t1_iload_c1", bus.iload, 32'hDEADBEEF);
    check("t1_addr_c1",  bus.ramaddr, 32'h40);
    tick_end();
    set_in(1'b0, 32'h40, 1'b0, 1'b0, '0, '0, R_FREE, 32'h0);
    tick_begin("t1c2");
    check("t1_iwait_c2", 32'(bus.iwait), 32'd1);
    tick_end();
    idle_cycle();

    // Simultaneous requests: dcache first, one dead cycle, then icache
    for (int c = 0; c < 8; c++) begin
      set_in(1'b1, 32'h80, 1'(c < 4), 1'b0, 32'h1000, '0, t2_rs[c], 32'hA0 + 32'(c));
      tick_begin("t2");
      if (c == 3) check("t2_dwait_c3", 32'(bus.dwait), 32'd0);
      if (c == 4) check("t2_dead_en",  32'({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}), 32'b0011);
      if (c == 7) check("t2_iwait_c7", 32'(bus.iwait), 32'd0);
      tick_end();
    end
    idle_cycle();

    // Read+write together: the write wins
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, '0, 1'b1, 1'b1, 32'h3100, 32'd5, t3_rs[c], 32'h77);
      tick_begin("t3");
      if (c > 0) begin
        check("t3_en",    32'({bus.ramREN, bus.ramWEN}), 32'b01);
        check("t3_addr",  bus.ramaddr, 32'h3100);
        check("t3_store", bus.ramstore, 32'd5);
      end
      if (c == 3) check("t3_dwait", 32'(bus.dwait), 32'd0);
      tick_end();
    end
    idle_cycle();

    // dcache withdraws after one BUSY cycle
    set_in(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, R_FREE, '0);
    tick_begin("t4c0"); tick_end();
    set_in(1'b0, '0, 1'b1, 1'b0, 32'h500, '0, R_BUSY, '0);
    tick_begin("t4c1"); tick_end();
    set_in(1'b0, '0, 1'b0, 1'b0, 32'h500, '0, R_BUSY, '0);
    tick_begin("t4c2");
    check("t4_abort_en",    32'({bus.ramREN, bus.ramWEN}), 32'd0);
    check("t4_abort_dwait", 32'(bus.dwait), 32'd1);
    tick_end();
    set_in(1'b0, '0, 1'b1, 1'b0, 32'h504, '0, R_ACCESS, 32'h11);
    tick_begin("t4c3");
    check("t4_idle_dwait", 32'(bus.dwait), 32'd1);
    tick_end();
    tick_begin("t4c4");
    check("t4_regrant_dwait", 32'(bus.dwait), 32'd0);
    tick_end();
    idle_cycle();

    // Asynchronous reset in the middle of a dcache write
    set_in(1'b0, '0, 1'b0, 1'b1, 32'h900, 32'h1234, R_BUSY, '0);
    tick_begin("t5c0"); tick_end();
    tick_begin("t5c1");
    check("t5_pre_wen", 32'(bus.ramWEN), 32'd1);
    #1 nrst = 1'b0;
    #1;
    check("t5_rst_en",    32'({bus.ramREN, bus.ramWEN}), 32'd0);
    check("t5_rst_dwait", 32'(bus.dwait), 32'd1);
    advance();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    bus.ramstate = R_ACCESS;
    tick_begin("t5c2");
    check("t5_post_idle", 32'({bus.ramWEN, bus.dwait}), 32'b01);
    tick_end();
    tick_begin("t5c3");
    check("t5_regrant", 32'(bus.dwait), 32'd0);
    tick_end();
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    idle_cycle();
    idle_cycle();

    // Continuous contention from both caches
    set_in(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, R_ACCESS, 32'h5A5A0000);
    dn = 0; in_i = 0; got_i = 1'b0;
`ifdef ARB_FAIR_EN
    for (int c = 0; c < 30 && !got_i; c++) begin
      tick_begin("fair");
      if (bus.iwait === 1'b0) begin
        got_i = 1'b1;
        check("fair_dstreak_clr", 32'(dut.dstreak), 32'd0);
      end else if (bus.dwait === 1'b0) begin
        dn++;
      end
      tick_end();
    end
    check("fair_igrant", 32'(got_i), 32'd1);
    check("fair_dcount", 32'(dn), 32'(LIMIT));
`else
    for (int c = 0; c < 20; c++) begin
      tick_begin("strict");
      if (bus.dwait === 1'b0) dn++;
      if (bus.iwait === 1'b0) in_i++;
      tick_end();
    end
    check("strict_dcount", 32'(dn), 32'd10);
    check("strict_icount", 32'(in_i), 32'd0);
`endif
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, R_FREE, '0);
    idle_cycle();

    // Random traffic, withdrawals and occasional resets
    for (int n = 0; n < 1500; n++) begin
      nrst = ($urandom_range(0, 199) != 0);
      r = int'($urandom_range(0, 9));
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 3) == 0, $urandom, $urandom,
             (r < 4) ? R_ACCESS : (r < 7) ? R_BUSY : (r < 9) ? R_FREE : R_ERROR,
             $urandom);
      tick_begin("rand");
      tick_end();
    end
    nrst = 1'b1;
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the instruction cache and the data cache onto the single-ported RAM. Sits directly downstream of both caches (driving their `iwait`/`dwait`, `iload`/`dload`) and upstream of the RAM model/controller. Grants are registered and held until the RAM reports `ACCESS`, so a cache's multi-word sequences (line fill, dirty write-back) never see a mid-access address swap. By default the data cache has priority; an optional fairness guard bounds instruction-fetch starvation.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive contested dcache completions before icache is forced a grant. Used only with `ARB_FAIR_EN`; legal range 1–15.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iwait` out 1: low only in the cycle an icache access completes.
- `iload` out 32: read data for icache.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: dcache write data.
- `dwait` out 1: low only in the cycle a dcache access completes.
- `dload` out 32: read data for dcache.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status; `FREE`=0, `BUSY`=1, `ACCESS`=2, `ERROR`=3.

## Operation
- FSM states: `IDLE`, `DGRANT`, `IGRANT`. Reset enters `IDLE`.
- `IDLE`:
  - All RAM enables are 0, `ramaddr`=0, `ramstore`=0, `iwait`=`dwait`=1.
  - If `dREN|dWEN`, go to `DGRANT`; else if `iREN`, go to `IGRANT`; else stay in `IDLE`.
- `DGRANT`:
  - `ramaddr`=`daddr`, `ramstore`=`dstore`, `ramWEN`=`dWEN`, `ramREN`=`dREN&~dWEN`. If `dREN` and `dWEN` are both high, the write wins.
  - When `ramstate`==`ACCESS`: `dwait`=0 and `dload`=`ramload` in that cycle, then return to `IDLE`.
  - `BUSY`, `FREE`, `ERROR`: hold `dwait`=1 and keep driving the request. `ERROR` is a retry.
  - If `dREN` and `dWEN` both drop before completion: drop the enables in that cycle, return to `IDLE`, no completion pulse.
- `IGRANT`: same as `DGRANT` using `iaddr`, `ramREN`=`iREN`, `ramWEN`=0, completion drives `iwait`=0 and `iload`=`ramload`. Withdrawal of `iREN` aborts the same way.
- `iwait` is 1 whenever the state is not `IGRANT`. `dwait` is 1 whenever the state is not `DGRANT`.
- `iload` and `dload` are 0 outside their completion cycle.

## Timing
- Reset values of all outputs: `iwait`=1, `dwait`=1, `iload`=0, `dload`=0, `ramREN`=0, `ramWEN`=0, `ramaddr`=0, `ramstore`=0. Fairness counter = 0.
- Minimum latency: request seen in `IDLE` at cycle 0, grant at cycle 1. If `ACCESS` arrives at cycle 1, the wait output is low at cycle 1.
- Every completion is followed by exactly one `IDLE` cycle (dead cycle). A two-word line fill therefore takes at least 4 cycles.
- Arbitration is sampled only in `IDLE`. A request arriving during another grant waits until that grant completes or aborts.
- Reset mid-grant: enables drop immediately (asynchronous), the access is abandoned, and no completion pulse is issued.

## Configuration
- `ARB_FAIR_EN` defined:
  - A 4-bit counter `dstreak` increments on each dcache completion for which `iREN`=1 in that same cycle.
  - `dstreak` clears on entry to `IGRANT`, and also on any dcache completion with `iREN`=0.
  - In `IDLE`, if `dstreak`==`STARVE_LIMIT` and `iREN`=1, go to `IGRANT` even if dcache is requesting.
- `ARB_FAIR_EN` undefined: strict dcache priority. The counter and `STARVE_LIMIT` logic are absent.

## Test plan
- Reset asserted mid-`DGRANT` with `dWEN`=1 -> `ramWEN`=0 and `dwait`=1 immediately; state `IDLE` after reset release.
- Lone icache read at `iaddr`=0x40, `ACCESS` on the first grant cycle, `ramload`=0xDEADBEEF -> `iwait`=0 and `iload`=0xDEADBEEF in cycle 1, `iwait`=1 in cycle 2.
- `iREN` and `dREN` raised together, RAM returns `ACCESS` after 2 `BUSY` cycles -> `dwait` low at cycle 3, then one `IDLE` cycle, then `IGRANT`; `iwait` low at cycle 7.
- `dREN`=`dWEN`=1, `daddr`=0x3100, `dstore`=5 -> `ramWEN`=1, `ramREN`=0, `ramaddr`=0x3100, `ramstore`=5 until `ACCESS`.
- `dREN` dropped after 1 `BUSY` cycle in `DGRANT` -> enables low in the same cycle, no `dwait` pulse, back in `IDLE`.
- `ARB_FAIR_EN` with `STARVE_LIMIT`=4; dcache requests continuously and `iREN` is held high -> exactly 4 dcache completions, then an icache grant, then `dstreak` reads 0.
